// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate cache controller.
// Lines are 4 words (16 bytes). Hits complete combinationally in the request
// cycle; misses write back a dirty victim (4 cycles) and then fill (4 cycles).
// Optional feature: define CACHE_STATS_EN to add saturating hit/miss counters
// (stat_hits, stat_misses).
module dm_cache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [31:0]     cpu_addr,
    input  logic [0:3][7:0] cpu_wdata,
    output logic [0:3][7:0] cpu_rdata,
    output logic            cpu_ready,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_wdata,
    input  logic [0:3][7:0] mem_rdata,
    output logic            mem_we
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_misses
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 4;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

    state_t                  state;
    logic [1:0]              cnt;
    logic [1:0]              cnt_nxt;
    logic [27:0]             miss_line;   // line address (addr[31:4]) of the pending miss
    logic [LINES-1:0]        valid;
    logic [LINES-1:0]        dirty;
    logic [TAG_W-1:0]        tag_arr  [LINES];
    logic [0:3][7:0]         data_arr [LINES][4];

    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [1:0]              req_word;
    logic [INDEX_BITS-1:0]   miss_idx;
    logic                    hit;
    logic                    unused_addr_bits;

    assign req_tag          = cpu_addr[31:INDEX_BITS+4];
    assign req_idx          = cpu_addr[INDEX_BITS+3:4];
    assign req_word         = cpu_addr[3:2];
    assign miss_idx         = miss_line[INDEX_BITS-1:0];
    assign cnt_nxt          = cnt + 2'd1;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign cpu_ready = (state == S_IDLE) && cpu_req && hit;

    // Load data is driven only while the request completes, zero otherwise.
    always_comb begin
        cpu_rdata = '0;
        if (cpu_ready) cpu_rdata = data_arr[req_idx][req_word];
    end

    // Control FSM: state, beat counter, line status bits and registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            miss_line <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_ready && cpu_we) dirty[req_idx] <= 1'b1;
                    if (cpu_req && !hit) begin
                        miss_line <= cpu_addr[31:4];
                        cnt       <= 2'd0;
                        if (valid[req_idx] && dirty[req_idx]) begin
                            // Present the first victim word in the first WB cycle.
                            state     <= S_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[req_idx], req_idx, 2'd0, 2'd0};
                            mem_wdata <= data_arr[req_idx][0];
                        end else begin
                            state    <= S_FILL;
                            mem_addr <= {cpu_addr[31:4], 4'd0};
                        end
                    end
                end
                S_WB: begin
                    if (cnt == 2'd3) begin
                        state     <= S_FILL;
                        cnt       <= 2'd0;
                        mem_we    <= 1'b0;
                        mem_addr  <= {miss_line, 4'd0};
                        mem_wdata <= '0;
                    end else begin
                        cnt       <= cnt_nxt;
                        mem_addr  <= {tag_arr[miss_idx], miss_idx, cnt_nxt, 2'd0};
                        mem_wdata <= data_arr[miss_idx][cnt_nxt];
                    end
                end
                S_FILL: begin
                    if (cnt == 2'd3) begin
                        state           <= S_IDLE;
                        cnt             <= 2'd0;
                        mem_addr        <= '0;
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_addr <= {miss_line, cnt_nxt, 2'd0};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data and tag arrays are not reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (cpu_ready && cpu_we) data_arr[req_idx][req_word] <= cpu_wdata;
        if (state == S_FILL) begin
            data_arr[miss_idx][cnt] <= mem_rdata;
            if (cnt == 2'd3) tag_arr[miss_idx] <= miss_line[27:INDEX_BITS];
        end
    end

`ifdef CACHE_STATS_EN
    logic after_fill;

    // Saturating hit/miss counters; the completion right after a fill is the miss, not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            after_fill  <= 1'b0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            after_fill <= (state == S_FILL) && (cnt == 2'd3);
            if ((state == S_IDLE) && cpu_req && !hit && (stat_misses != 32'hFFFF_FFFF))
                stat_misses <= stat_misses + 32'd1;
            if (cpu_ready && !after_fill && (stat_hits != 32'hFFFF_FFFF))
                stat_hits <= stat_hits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench for dm_cache_ctrl with a transaction-level
// cache/memory model and a per-cycle output check.
module tb_dm_cache_ctrl;
    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [0:3][7:0] cpu_wdata;
    logic [0:3][7:0] cpu_rdata;
    logic            cpu_ready;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_wdata;
    logic [0:3][7:0] mem_rdata;
    logic            mem_we;
`ifdef CACHE_STATS_EN
    logic [31:0]     stat_hits;
    logic [31:0]     stat_misses;
`endif

    dm_cache_ctrl #(.INDEX_BITS(3)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Word values are kept numerically; byte 0 of the port is the low byte.
    function automatic logic [31:0] bsw(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = {16'hC0DE, 6'd0, i[9:0]};
        if (i == 32'h40) w = 32'hDEADBEEF;
        return w;
    endfunction

    // Main memory: combinational read, write on the clock edge.
    logic [31:0] mem [1024];
    bit          mem_loaded = 1'b0;
    assign mem_rdata = bsw(mem[mem_addr[11:2]]);
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= bsw(mem_wdata);
        end
    end

    // Reference model: cache contents and the memory image it implies.
    logic        ref_valid [8];
    logic        ref_dirty [8];
    logic [24:0] ref_tag   [8];
    logic [31:0] ref_data  [8][4];
    logic [31:0] ref_mem   [1024];

    // Expected outputs for the current cycle.
    logic        exp_ready, exp_we, exp_chk_wd, exp_chk_rd;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [31:0] last_rdata;
    logic        seen_ready;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        exp_ready = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_wd = 32'd0;
        exp_chk_wd = 1'b0; exp_chk_rd = 1'b0; exp_rd = 32'd0;
    endtask

    // One clock cycle: compare every output at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        check("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        if (exp_chk_wd) check("mem_wdata", 32'(mem_wdata), bsw(exp_wd));
        if (!exp_ready) check("cpu_rdata_zero", 32'(cpu_rdata), 32'd0);
        else if (exp_chk_rd) check("cpu_rdata", 32'(cpu_rdata), bsw(exp_rd));
        seen_ready = cpu_ready;
        if (cpu_ready) last_rdata = 32'(cpu_rdata);
        @(posedge clk);
        #1;
    endtask

    // One CPU access: the model predicts the cycle-by-cycle memory traffic and completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wval,
                          input int drop_at, input int rst_at, output int rdy_at);
        logic [2:0]  ix;
        logic [24:0] tg;
        logic [1:0]  wd;
        logic [31:0] a;
        logic [31:0] rd_val;
        logic        s_we[$];
        logic [31:0] s_addr[$];
        logic [31:0] s_wd[$];
        bit          hit, aborted, held;
        ix = addr[6:4]; tg = addr[31:7]; wd = addr[3:2];
        hit = ref_valid[ix] && (ref_tag[ix] == tg);
        aborted = 1'b0; held = 1'b0;
        if (!hit) begin
            s_we.push_back(1'b0); s_addr.push_back(32'd0); s_wd.push_back(32'd0);
            if (ref_valid[ix] && ref_dirty[ix])
                for (int k = 0; k < 4; k++) begin
                    s_we.push_back(1'b1); s_addr.push_back({ref_tag[ix], ix, 2'(k), 2'b00});
                    s_wd.push_back(ref_data[ix][k]);
                end
            for (int k = 0; k < 4; k++) begin
                s_we.push_back(1'b0); s_addr.push_back({addr[31:4], 2'(k), 2'b00});
                s_wd.push_back(32'd0);
            end
            a = {addr[31:4], 4'd0};
            rd_val = ref_mem[{a[11:4], wd}];
        end else begin
            rd_val = ref_data[ix][wd];
        end
        s_we.push_back(1'b0); s_addr.push_back(32'd0); s_wd.push_back(32'd0);

        rdy_at = -1;
        cpu_we = we; cpu_addr = addr; cpu_wdata = bsw(wval);
        for (int c = 0; c < s_we.size(); c++) begin
            cpu_req = (drop_at < 0) || (c < drop_at);
            exp_we = s_we[c]; exp_addr = s_addr[c]; exp_wd = s_wd[c]; exp_chk_wd = s_we[c];
            exp_ready = (c == s_we.size() - 1) && cpu_req;
            exp_chk_rd = !we; exp_rd = rd_val;
            held = exp_ready;
            if (c == rst_at) begin
                rst = 1'b1;
                set_idle();
                exp_chk_wd = 1'b1;
            end
            tick();
            if (seen_ready) rdy_at = c;
            if (c == rst_at) begin
                aborted = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0; rst = 1'b0;
        set_idle();

        if (aborted) begin
            for (int i = 0; i < 8; i++) begin ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; end
        end else begin
            if (!hit) begin
                if (ref_valid[ix] && ref_dirty[ix])
                    for (int k = 0; k < 4; k++) begin
                        a = {ref_tag[ix], ix, 2'(k), 2'b00};
                        ref_mem[a[11:2]] = ref_data[ix][k];
                    end
                for (int k = 0; k < 4; k++) begin
                    a = {addr[31:4], 2'(k), 2'b00};
                    ref_data[ix][k] = ref_mem[a[11:2]];
                end
                ref_tag[ix] = tg; ref_valid[ix] = 1'b1; ref_dirty[ix] = 1'b0;
            end
            if (we && held) begin
                ref_data[ix][wd] = wval;
                ref_dirty[ix] = 1'b1;
            end
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 8; i++) begin ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; end
        last_rdata = 32'd0; seen_ready = 1'b0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = '0;
        set_idle();
        exp_chk_wd = 1'b1;
        repeat (2) tick();
`ifdef CACHE_STATS_EN
        check("stat_hits_reset", stat_hits, 32'd0);
        check("stat_misses_reset", stat_misses, 32'd0);
`endif
        rst = 1'b0;
        set_idle();
        tick();

        // Clean miss then repeat hit.
        access(1'b0, 32'h100, 32'd0, -1, -1, r);
        check("t1_miss_latency", 32'(r), 32'd5);
        check("t1_rdata_bytes", last_rdata, 32'hEFBEADDE);
        tick();
        access(1'b0, 32'h100, 32'd0, -1, -1, r);
        check("t1_hit_latency", 32'(r), 32'd0);
        tick();

        // Store hit stays in the cache.
        access(1'b1, 32'h104, 32'h11223344, -1, -1, r);
        check("t2_store_latency", 32'(r), 32'd0);
        tick();
        check("t2_mem_unchanged", mem[32'h41], 32'hC0DE0041);
        access(1'b0, 32'h104, 32'd0, -1, -1, r);
        check("t2_load_latency", 32'(r), 32'd0);
        check("t2_load_rdata", last_rdata, 32'h44332211);
        tick();

        // Dirty eviction by an aliasing address.
        access(1'b0, 32'h180, 32'd0, -1, -1, r);
        check("t3_dirty_latency", 32'(r), 32'd9);
        tick();
        check("t3_wb_word0", mem[32'h40], 32'hDEADBEEF);
        check("t3_wb_word1", mem[32'h41], 32'h11223344);
        check("t3_wb_word2", mem[32'h42], 32'hC0DE0042);
`ifdef CACHE_STATS_EN
        check("stat_misses", stat_misses, 32'd2);
        check("stat_hits", stat_hits, 32'd3);
`endif

        // Request dropped mid-miss: line still installed.
        access(1'b0, 32'h200, 32'd0, 2, -1, r);
        check("t4_no_ready", 32'(r), 32'hFFFF_FFFF);
        tick();
        access(1'b0, 32'h200, 32'd0, -1, -1, r);
        check("t4_hit_after_drop", 32'(r), 32'd0);
        tick();

        // Store miss allocates, later evicted with its new data.
        access(1'b1, 32'h300, 32'hA5A55A5A, -1, -1, r);
        check("store_miss_latency", 32'(r), 32'd5);
        tick();
        access(1'b0, 32'h200, 32'd0, -1, -1, r);
        check("alias_dirty_latency", 32'(r), 32'd9);
        tick();
        check("alias_wb_data", mem[32'hC0], 32'hA5A55A5A);

        // Reset during FILL cnt=2 invalidates everything.
        access(1'b0, 32'h240, 32'd0, -1, 3, r);
        check("t5_no_ready", 32'(r), 32'hFFFF_FFFF);
        tick();
        access(1'b0, 32'h240, 32'd0, -1, -1, r);
        check("t5_miss_again", 32'(r), 32'd5);
        tick();
        access(1'b0, 32'h200, 32'd0, -1, -1, r);
        check("t5_other_line_invalid", 32'(r), 32'd5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
